// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and constants for the TDM demultiplexer.
//   state_e      : receive FSM states (IDLE, COLLECT)
//   TDM_DEF_*    : default slot-index width, channel count and channel width
//   ch_offset()  : bit offset of channel k in a packed channel word (k*W)
package tdm_demux_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int unsigned TDM_DEF_N = 3;
    localparam int unsigned TDM_DEF_M = 8;
    localparam int unsigned TDM_DEF_W = 1;

    function automatic int unsigned ch_offset(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-M slot index counter.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : force count to 1 (slot 0 is being written this cycle)
//   inc      : advance count, wrapping from M-1 to 0; load has priority
//   count    : current slot index (never reaches M or above)
//   wrap     : count is at M-1, the last slot of a frame
module tdm_slot_counter #(
    parameter int unsigned N = 3,
    parameter int unsigned M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    output logic [N-1:0] count,
    output logic         wrap
);

    localparam logic [N-1:0] LAST = N'(M - 1);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    assign wrap  = (count_q == LAST);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = N'(1);
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + N'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a TDM channel sweep. Collects one W-bit sample
// per valid slot (slot 0 flagged by frame_start) and publishes the M-channel
// word on Y once the last slot of a frame has arrived.
//   clk, rst    : clock, asynchronous active-high reset
//   din         : slot sample, qualified by din_valid
//   frame_start : marks slot 0; only meaningful with din_valid
//   Y           : channel word, channel k at Y[k*W +: W] (registered)
//   slot        : slot index the next valid sample is written to
//   busy        : high while a frame is being collected
//   frame_done  : one-cycle pulse, Y updated this cycle
//   frame_err   : one-cycle pulse when a frame is restarted mid-way
// Build option: TDM_DEMUX_LIVE_EN writes each sample straight into Y
// (no shadow buffer); otherwise Y is updated atomically per frame.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N = TDM_DEF_N,
    parameter int unsigned M = TDM_DEF_M,
    parameter int unsigned W = TDM_DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_start,
    output logic [M*W-1:0] Y,
    output logic [N-1:0]   slot,
    output logic           busy,
    output logic           frame_done,
    output logic           frame_err
);

    state_e         state_q, state_d;
    logic [M*W-1:0] y_q, y_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
`ifndef TDM_DEMUX_LIVE_EN
    logic [M*W-1:0] shadow_q, shadow_d;
`endif

    logic           cnt_load;
    logic           cnt_inc;
    logic           cnt_wrap;
    logic [N-1:0]   slot_w;
    logic [N-1:0]   wr_idx;
    logic [M*W-1:0] wr_word;

    tdm_slot_counter #(
        .N (N),
        .M (M)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .count (slot_w),
        .wrap  (cnt_wrap)
    );

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
`ifndef TDM_DEMUX_LIVE_EN
        shadow_d = shadow_q;
        wr_word  = shadow_q;
`else
        wr_word  = y_q;
`endif

        // Sample lands in slot 0 on frame_start, otherwise at the counter.
        // In IDLE only a frame_start sample is accepted.
        wr_idx = frame_start ? '0 : slot_w;
        if (din_valid && (frame_start || (state_q == COLLECT))) begin
            for (int unsigned k = 0; k < M; k++) begin
                if (wr_idx == N'(k)) begin
                    wr_word[ch_offset(k, W) +: W] = din;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (din_valid && frame_start) begin
                    cnt_load = 1'b1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    if (frame_start) begin
                        cnt_load = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (cnt_wrap) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
`ifndef TDM_DEMUX_LIVE_EN
                            // Publish the buffer with the final sample merged in.
                            y_d = wr_word;
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef TDM_DEMUX_LIVE_EN
        y_d = wr_word;
`else
        shadow_d = wr_word;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            y_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifndef TDM_DEMUX_LIVE_EN
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifndef TDM_DEMUX_LIVE_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign Y          = y_q;
    assign slot       = slot_w;
    assign busy       = (state_q == COLLECT);
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed bench for tdm_demux with two instances,
// A (N=3, M=8, W=1) and B (N=3, M=5, W=2).
module tb_tdm_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic       rst_a, a_valid, a_fs, a_din;
    logic [7:0] a_y;
    logic [2:0] a_slot;
    logic       a_busy, a_done, a_err;

    // Instance B
    logic       rst_b, b_valid, b_fs;
    logic [1:0] b_din;
    logic [9:0] b_y;
    logic [2:0] b_slot;
    logic       b_busy, b_done, b_err;

    tdm_demux #(.N(3), .M(8), .W(1)) dut_a (
        .clk(clk), .rst(rst_a), .din(a_din), .din_valid(a_valid),
        .frame_start(a_fs), .Y(a_y), .slot(a_slot), .busy(a_busy),
        .frame_done(a_done), .frame_err(a_err)
    );

    tdm_demux #(.N(3), .M(5), .W(2)) dut_b (
        .clk(clk), .rst(rst_b), .din(b_din), .din_valid(b_valid),
        .frame_start(b_fs), .Y(b_y), .slot(b_slot), .busy(b_busy),
        .frame_done(b_done), .frame_err(b_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor for instance A, sampled on the falling edge.
    int unsigned cyc = 0;
    int unsigned a_done_cnt = 0, a_err_cnt = 0, a_both_cnt = 0;
    int unsigned a_done_cyc_last = 0, a_done_cyc_prev = 0;
    logic [7:0]  a_y_done_last = '0, a_y_done_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_done) begin
            a_done_cnt++;
            a_done_cyc_prev = a_done_cyc_last;
            a_done_cyc_last = cyc;
            a_y_done_prev   = a_y_done_last;
            a_y_done_last   = a_y;
        end
        if (a_err) a_err_cnt++;
        if (a_done && a_err) a_both_cnt++;
    end

    task automatic a_drive(input logic v, input logic fs, input logic d);
        @(negedge clk);
        a_valid = v;
        a_fs    = fs;
        a_din   = d;
    endtask

    task automatic b_drive(input logic v, input logic fs, input logic [1:0] d);
        @(negedge clk);
        b_valid = v;
        b_fs    = fs;
        b_din   = d;
    endtask

    // Full frame on A; optional idle cycle between samples with slot/Y checks.
    task automatic a_frame(input logic [7:0] val, input bit gaps, input logic [7:0] y_hold);
        for (int i = 0; i < 8; i++) begin
            a_drive(1'b1, i == 0, val[i]);
            if (gaps && i < 7) begin
                a_drive(1'b0, 1'b0, 1'b0);
                check_eq("a_gap_slot", 32'(a_slot), 32'(i + 1));
                check_eq("a_gap_y", 32'(a_y), 32'(y_hold));
            end
        end
    endtask

    task automatic b_frame(input logic [9:0] val);
        for (int i = 0; i < 5; i++) begin
            b_drive(1'b1, i == 0, val[2*i +: 2]);
        end
    endtask

    logic [7:0]  pat;
    int unsigned d0, e0;

    initial begin
        rst_a = 1'b1; a_valid = 1'b0; a_fs = 1'b0; a_din = 1'b0;
        rst_b = 1'b1; b_valid = 1'b0; b_fs = 1'b0; b_din = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        check_eq("a_rst_y", 32'(a_y), 32'h00);
        check_eq("a_rst_slot", 32'(a_slot), 32'd0);
        check_eq("a_rst_busy", 32'(a_busy), 32'd0);
        check_eq("a_rst_pulses", 32'({a_done, a_err}), 32'd0);
        check_eq("b_rst_y", 32'(b_y), 32'h000);

        // Valid samples without frame_start are discarded in IDLE
        repeat (3) a_drive(1'b1, 1'b0, 1'b1);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_idle_y", 32'(a_y), 32'h00);
        check_eq("a_idle_slot", 32'(a_slot), 32'd0);
        check_eq("a_idle_busy", 32'(a_busy), 32'd0);
        check_eq("a_idle_done_cnt", a_done_cnt, 32'd0);

        // Single frame 8'h5A, no gaps
        a_frame(8'h5A, 1'b0, 8'h00);
        check_eq("a_f1_busy_last", 32'(a_busy), 32'd1);
        check_eq("a_f1_y_before", 32'(a_y), 32'h00);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_f1_done", 32'(a_done), 32'd1);
        check_eq("a_f1_y", 32'(a_y), 32'h5A);
        check_eq("a_f1_slot", 32'(a_slot), 32'd0);
        check_eq("a_f1_busy", 32'(a_busy), 32'd0);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_f1_done_drop", 32'(a_done), 32'd0);
        check_eq("a_f1_done_cnt", a_done_cnt, 32'd1);

        // Same frame with idle cycles between samples
        d0 = a_done_cnt;
        a_frame(8'h5A, 1'b1, 8'h5A);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_f2_done", 32'(a_done), 32'd1);
        check_eq("a_f2_y", 32'(a_y), 32'h5A);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_f2_done_cnt", a_done_cnt - d0, 32'd1);

        // Early restart at slot 5, then full frame 8'hA5
        e0 = a_err_cnt;
        d0 = a_done_cnt;
        a_drive(1'b1, 1'b1, 1'b1);
        repeat (4) a_drive(1'b1, 1'b0, 1'b1);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_ab_slot5", 32'(a_slot), 32'd5);
        pat = 8'hA5;
        a_drive(1'b1, 1'b1, pat[0]);
        a_drive(1'b1, 1'b0, pat[1]);
        check_eq("a_ab_err", 32'(a_err), 32'd1);
        check_eq("a_ab_done", 32'(a_done), 32'd0);
        check_eq("a_ab_y", 32'(a_y), 32'h5A);
        check_eq("a_ab_slot", 32'(a_slot), 32'd1);
        check_eq("a_ab_busy", 32'(a_busy), 32'd1);
        for (int i = 2; i < 8; i++) a_drive(1'b1, 1'b0, pat[i]);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_ab_f_done", 32'(a_done), 32'd1);
        check_eq("a_ab_f_y", 32'(a_y), 32'hA5);
        check_eq("a_ab_f_err", 32'(a_err), 32'd0);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_ab_err_cnt", a_err_cnt - e0, 32'd1);
        check_eq("a_ab_done_cnt", a_done_cnt - d0, 32'd1);

        // Back-to-back frames, zero bubble
        d0 = a_done_cnt;
        a_frame(8'h5A, 1'b0, 8'h00);
        a_frame(8'hFF, 1'b0, 8'h00);
        a_drive(1'b0, 1'b0, 1'b0);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_b2b_done_cnt", a_done_cnt - d0, 32'd2);
        check_eq("a_b2b_spacing", a_done_cyc_last - a_done_cyc_prev, 32'd8);
        check_eq("a_b2b_y1", 32'(a_y_done_prev), 32'h5A);
        check_eq("a_b2b_y2", 32'(a_y_done_last), 32'hFF);
        check_eq("a_b2b_y", 32'(a_y), 32'hFF);

        // Reset at slot 4, then frame 8'h3C
        d0 = a_done_cnt;
        e0 = a_err_cnt;
        pat = 8'h3C;
        a_drive(1'b1, 1'b1, 1'b1);
        repeat (3) a_drive(1'b1, 1'b0, 1'b0);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_mr_slot4", 32'(a_slot), 32'd4);
        rst_a = 1'b1;
        #1;
        check_eq("a_mr_y", 32'(a_y), 32'h00);
        check_eq("a_mr_slot", 32'(a_slot), 32'd0);
        check_eq("a_mr_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 8; i++) a_drive(1'b1, i == 0, pat[i]);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_mr_f_done", 32'(a_done), 32'd1);
        check_eq("a_mr_f_y", 32'(a_y), 32'h3C);
        a_drive(1'b0, 1'b0, 1'b0);
        check_eq("a_mr_done_cnt", a_done_cnt - d0, 32'd1);
        check_eq("a_mr_err_cnt", a_err_cnt - e0, 32'd0);
        check_eq("a_never_both", a_both_cnt, 32'd0);

        // Instance B: M=5, W=2. Channels {3,1,2,0,3} -> 10'h327
        b_frame(10'h327);
        check_eq("b_f1_slot_last", 32'(b_slot), 32'd4);
        b_drive(1'b0, 1'b0, 2'b00);
        check_eq("b_f1_done", 32'(b_done), 32'd1);
        check_eq("b_f1_y", 32'(b_y), 32'h327);
        check_eq("b_f1_slot_wrap", 32'(b_slot), 32'd0);
        check_eq("b_f1_busy", 32'(b_busy), 32'd0);

        // B reset at slot 4, then channels {0,1,2,3,1} -> 10'h1E4
        b_drive(1'b1, 1'b1, 2'd2);
        repeat (3) b_drive(1'b1, 1'b0, 2'd1);
        b_drive(1'b0, 1'b0, 2'd0);
        check_eq("b_mr_slot4", 32'(b_slot), 32'd4);
        rst_b = 1'b1;
        #1;
        check_eq("b_mr_y", 32'(b_y), 32'h000);
        check_eq("b_mr_slot", 32'(b_slot), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        check_eq("b_mr_pulses", 32'({b_done, b_err}), 32'd0);
        b_frame(10'h1E4);
        b_drive(1'b0, 1'b0, 2'd0);
        check_eq("b_f2_done", 32'(b_done), 32'd1);
        check_eq("b_f2_y", 32'(b_y), 32'h1E4);
        check_eq("b_f2_slot", 32'(b_slot), 32'd0);
        b_drive(1'b0, 1'b0, 2'd0);
        check_eq("b_f2_done_drop", 32'(b_done), 32'd0);
        check_eq("b_f2_y_hold", 32'(b_y), 32'h1E4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
